// File: rtl/mem_arbiter.sv
// Serializes I-cache and D-cache line requests onto one shared memory port,
// routes each mem_ready back to its owner, and flags transactions that stall.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t      state, state_nxt;
  logic        last_d;
  logic [15:0] wd_cnt;
  logic        grant_i, grant_d, done_i, done_d;
  logic        d_pend, serving;

  // The I-cache is read-only; its write strobe is deliberately dropped.
  logic unused_i_write;
  assign unused_i_write = i_write;

  assign d_pend  = d_read | d_write;
  assign serving = (state == SERVE_I) || (state == SERVE_D);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done_i    = 1'b0;
    done_d    = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie D wins unless D had the previous grant.
        if (d_pend && (!i_read || !last_d)) begin
          grant_d   = 1'b1;
          state_nxt = SERVE_D;
        end else if (i_read) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end
      end
      SERVE_I: begin
        if (mem_ready) begin
          done_i    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      SERVE_D: begin
        if (mem_ready) begin
          done_d    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d      <= 1'b0;
      wd_cnt      <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;

      if (grant_i || grant_d) begin
        last_d    <= grant_d;
        wd_cnt    <= '0;
        mem_addr  <= grant_d ? d_addr : i_addr;
        // A D request with both strobes serves the write; the read stays pending.
        mem_read  <= grant_i | (d_read & ~d_write);
        mem_write <= grant_d & d_write;
        if (grant_d) mem_wdata <= d_wdata;
      end

      if (done_i) begin
        i_rdata <= mem_rdata;
        i_ready <= 1'b1;
      end
      if (done_d) begin
        d_rdata <= mem_rdata;
        d_ready <= 1'b1;
      end
      if (done_i || done_d) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end

      // Watchdog only flags; the transaction keeps waiting for memory.
      if (serving && !mem_ready) begin
        if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
        if (({1'b0, wd_cnt} + 17'd1) >= 17'(TIMEOUT)) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one arbiter between the I-cache and D-cache miss/write-back ports and a single shared slow memory. The I-side and D-side 128-bit line requests are serialized onto one memory port, and each `mem_ready` is routed back to the cache that owns the transaction. A watchdog flags a memory transaction that never completes.

## Interface
- `ADDR_W`, 28: line address width (byte address bits [31:4]).
- `DATA_W`, 128: line width.
- `TIMEOUT`, 1023: cycles a granted transaction may wait for `mem_ready` before `err_timeout` sets. Range 1..65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_read` in 1: I-cache line read request; held until `i_ready`.
- `i_write` in 1: I-cache write request; ignored (the I-cache is read-only).
- `i_addr` in ADDR_W: I-cache line address.
- `i_rdata` out DATA_W: line returned to the I-cache.
- `i_ready` out 1: one-cycle completion pulse to the I-cache.
- `d_read`, `d_write` in 1: D-cache line read / write-back request; held until `d_ready`.
- `d_addr` in ADDR_W, `d_wdata` in DATA_W: D-cache line address and write data.
- `d_rdata` out DATA_W, `d_ready` out 1: D-cache return data and completion pulse.
- `mem_read`, `mem_write` out 1: shared memory command.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: shared memory address and write data.
- `mem_rdata` in DATA_W, `mem_ready` in 1: shared memory response.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE, only I request pending (`i_read`): capture `i_addr`, go to SERVE_I.
- IDLE, only D request pending (`d_read|d_write`): capture `d_addr`, `d_wdata` and command, go to SERVE_D.
- IDLE, both pending: alternate using a `last_d` flag.
  - D is granted unless `last_d`=1.
  - `last_d` updates on every grant.
  - Reset value of `last_d` is 0, so D wins the first tie.
- D with both `d_read` and `d_write` high: the write is served, `mem_read`=0. The read stays pending and is taken in a later grant.
- SERVE_x: `mem_addr`, `mem_wdata`, `mem_read` and `mem_write` are driven from the captured registers, stable for the whole transaction. A cache changing its inputs mid-transaction has no effect.
- On `mem_ready` in SERVE_x:
  - capture `mem_rdata` into `x_rdata`;
  - pulse `x_ready` for exactly one cycle;
  - drop the memory command;
  - go to RELEASE.
- RELEASE: one bubble cycle, during which no request is sampled. The cache drops or changes its request in this cycle, so a stale request is never re-served. RELEASE always goes to IDLE.
- `mem_ready` seen in IDLE or RELEASE is ignored; no ready is forwarded.
- Watchdog:
  - a 16-bit counter clears on grant and increments each SERVE_x cycle without `mem_ready`;
  - reaching `TIMEOUT` sets `err_timeout`, which stays set until reset;
  - the transaction keeps waiting and is not aborted.
- `i_write` never reaches memory.

## Timing
- Reset (async, `rst_n`=0) returns to IDLE with all outputs 0: `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `i_ready`, `d_ready`, `i_rdata`, `d_rdata`, `err_timeout`.
- Reset mid-transaction abandons the transaction. No ready is issued, and the memory command drops asynchronously.
- All outputs are registered.
- Sequence for a request first seen high at edge t:
  - t+1: `mem_*` asserted.
  - `mem_ready` sampled high at edge r: `x_ready`=1 and `x_rdata` valid at r+1; `mem_read` and `mem_write` are 0 from r+1.
  - r+1: RELEASE. r+2: IDLE. New grants are possible from edge r+2, with `mem_*` asserted at r+3.
- Minimum turnaround with zero-wait memory (`mem_ready` at t+1): 3 cycles per transaction.
- `x_rdata` holds its value until the next completion for that port.

## Test plan
- Single I read, `i_addr`=0x0000040, memory ready after 4 cycles with rdata=0x0123…CDEF -> `mem_read`=1 with `mem_addr`=0x0000040 for exactly 5 cycles; `i_ready` for one cycle with the matching `i_rdata`; `d_ready` stays 0.
- D write-back, `d_addr`=0x0000100, `d_wdata`=all-0xA5 -> `mem_write`=1 with the same address and data until ready; `mem_read`=0; `d_ready` pulses once.
- I and D both requesting continuously for 6 transactions -> grants alternate D,I,D,I,D,I; each port completes 3 transactions; no back-to-back duplicate.
- Cache changes `d_addr` to 0x0000200 mid-transaction -> `mem_addr` stays 0x0000100 until `mem_ready`.
- `TIMEOUT`=8, memory never ready -> `err_timeout` rises after 8 wait cycles and stays 1. After memory later readies, the transaction completes normally and `err_timeout` remains 1.
- `rst_n` low during SERVE_D -> all outputs 0 immediately with no `d_ready`. After release, a new I request is served from IDLE.
